sa_blkbox_src_gen: RTL

//  Parametrised successor to the single-bit constant tie-off source.

---
 rtl/sa_blkbox_src_gen.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/sa_blkbox_src_gen.sv
// sa_blkbox_src_gen
// Deterministic valid/ready pattern source that stands in for a black-boxed
// partition. While idle every output is a zero tie-off. After a start pulse
// it streams CHANNELS lanes of WIDTH bits per beat in one of four patterns,
// for a programmed number of beats or endlessly.
module sa_blkbox_src_gen #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 16
) (
  input  logic                        nvdla_core_clk,
  input  logic                        nvdla_core_rstn,
  input  logic [1:0]                  cfg_mode,
  input  logic [WIDTH-1:0]            cfg_const,
  input  logic [CNT_W-1:0]            cfg_len,
  input  logic                        start,
  input  logic                        abort,
  output logic                        busy,
  output logic                        done,
  output logic                        out_pvld,
  input  logic                        out_prdy,
  output logic [CHANNELS*WIDTH-1:0]   out_pd
);

  localparam int PD_W = CHANNELS * WIDTH;

  localparam logic [1:0] MODE_ZERO  = 2'd0;
  localparam logic [1:0] MODE_CONST = 2'd1;
  localparam logic [1:0] MODE_INCR  = 2'd2;
  localparam logic [1:0] MODE_WALK1 = 2'd3;

  localparam logic [WIDTH-1:0] LANE_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t            state_r;
  state_t            state_s;

  logic [1:0]        mode_r;
  logic [WIDTH-1:0]  cst_r;
  logic [CNT_W-1:0]  len_r;
  logic [CNT_W-1:0]  n_r;

  logic [1:0]        mode_s;
  logic [WIDTH-1:0]  cst_s;
  logic [CNT_W-1:0]  len_s;
  logic [CNT_W-1:0]  n_s;
  logic              busy_s;
  logic              done_s;
  logic              pvld_s;
  logic [PD_W-1:0]   pd_s;

  logic              accept_s;
  logic              last_s;

  // Packed lane data for beat n of the given pattern; arithmetic wraps mod 2^WIDTH.
  function automatic logic [PD_W-1:0] beat_pd(
    input logic [1:0]       mode,
    input logic [WIDTH-1:0] cst,
    input logic [CNT_W-1:0] n
  );
    logic [PD_W-1:0]  pd;
    logic [WIDTH-1:0] lane;
    logic [63:0]      idx;
    pd = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      idx = 64'(n) + 64'(c);
      case (mode)
        MODE_ZERO:  lane = '0;
        MODE_CONST: lane = cst;
        MODE_INCR:  lane = cst + WIDTH'(64'(n) * 64'(CHANNELS) + 64'(c));
        MODE_WALK1: lane = LANE_ONE << (idx % 64'(WIDTH));
        default:    lane = '0;
      endcase
      pd[c*WIDTH +: WIDTH] = lane;
    end
    return pd;
  endfunction

  // A beat is delivered when valid meets ready; the final beat ends a finite stream.
  always_comb begin
    accept_s = out_pvld & out_prdy;
    last_s   = accept_s && (len_r != '0) && (n_r == (len_r - CNT_ONE));
  end

  // State register.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic: abort always wins over start and over the final beat.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start && !abort) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (abort || last_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RUN;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Output/datapath logic: next values of every registered output and the cfg latches.
  always_comb begin
    mode_s = mode_r;
    cst_s  = cst_r;
    len_s  = len_r;
    n_s    = n_r;
    busy_s = busy;
    done_s = 1'b0;
    pvld_s = out_pvld;
    pd_s   = out_pd;
    case (state_r)
      ST_IDLE: begin
        if (start && !abort) begin
          mode_s = cfg_mode;
          cst_s  = cfg_const;
          len_s  = cfg_len;
          n_s    = '0;
          busy_s = 1'b1;
          pvld_s = 1'b1;
          pd_s   = beat_pd(cfg_mode, cfg_const, '0);
        end else begin
          busy_s = 1'b0;
          pvld_s = 1'b0;
          pd_s   = '0;
        end
      end
      ST_RUN: begin
        if (abort) begin
          busy_s = 1'b0;
          pvld_s = 1'b0;
          pd_s   = '0;
        end else if (last_s) begin
          n_s    = n_r + CNT_ONE;
          busy_s = 1'b0;
          pvld_s = 1'b0;
          pd_s   = '0;
          done_s = 1'b1;
        end else if (accept_s) begin
          n_s    = n_r + CNT_ONE;
          pd_s   = beat_pd(mode_r, cst_r, n_r + CNT_ONE);
        end else begin
          pd_s   = out_pd;
        end
      end
      default: begin
        busy_s = 1'b0;
        pvld_s = 1'b0;
        pd_s   = '0;
      end
    endcase
  end

  // Output and configuration registers.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      mode_r   <= 2'd0;
      cst_r    <= '0;
      len_r    <= '0;
      n_r      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      out_pvld <= 1'b0;
      out_pd   <= '0;
    end else begin
      mode_r   <= mode_s;
      cst_r    <= cst_s;
      len_r    <= len_s;
      n_r      <= n_s;
      busy     <= busy_s;
      done     <= done_s;
      out_pvld <= pvld_s;
      out_pd   <= pd_s;
    end
  end

endmodule
